// File: rtl/div_arbiter.sv
// div_arbiter: shares one DivisorUnit among NREQ requesters.
// Grants go round-robin, and only one operation is in flight at a time.
// Divide-by-zero and signed overflow are answered here without starting the divider.
// Optional build macro DIV_REUSE_EN keeps the last divider-computed result.
// A matching {dividend, divisor, usigned} request is then answered from that
// cached result without a new divider pass.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrating; req_ready asserted for the granted requester
// ISSUE  | single-cycle div_valid start pulse to the divider
// WAIT   | divider busy; operands held until div_res_ready
// RESP   | rsp_valid asserted; result held until rsp_ready
module div_arbiter #(
  parameter int parallelism = 32,
  parameter int NREQ        = 2,
  parameter int IDW         = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0]               req_usigned,
  input  logic [NREQ-1:0]               req_rem,
  input  logic [NREQ*parallelism-1:0]   req_dividend,
  input  logic [NREQ*parallelism-1:0]   req_divisor,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [parallelism-1:0]        rsp_data,
  output logic                          rsp_divzero,
  output logic                          rsp_overflow,
  output logic                          div_valid,
  output logic                          div_usigned,
  output logic [parallelism-1:0]        div_dividend,
  output logic [parallelism-1:0]        div_divisor,
  input  logic [parallelism-1:0]        div_quotient,
  input  logic [parallelism-1:0]        div_reminder,
  input  logic                          div_res_ready
);

  localparam logic [parallelism-1:0] MIN_NEG = {1'b1, {(parallelism-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [parallelism-1:0]   op_dividend_q, op_dividend_d;
  logic [parallelism-1:0]   op_divisor_q, op_divisor_d;
  logic                     op_usigned_q, op_usigned_d;
  logic                     op_rem_q, op_rem_d;
  logic [IDW-1:0]           rsp_id_q, rsp_id_d;
  logic [parallelism-1:0]   rsp_data_q, rsp_data_d;
  logic                     rsp_divzero_q, rsp_divzero_d;
  logic                     rsp_overflow_q, rsp_overflow_d;

  logic                     gnt_found;
  logic [IDW-1:0]           gnt_idx;
  logic [parallelism-1:0]   sel_dividend, sel_divisor;
  logic                     sel_usigned, sel_rem;
  logic                     cache_hit;

`ifdef DIV_REUSE_EN
  logic                     cache_vld_q, cache_vld_d;
  logic [parallelism-1:0]   cache_dividend_q, cache_dividend_d;
  logic [parallelism-1:0]   cache_divisor_q, cache_divisor_d;
  logic                     cache_usigned_q, cache_usigned_d;
  logic [parallelism-1:0]   cache_quo_q, cache_quo_d;
  logic [parallelism-1:0]   cache_rem_q, cache_rem_d;

  assign cache_hit = cache_vld_q && (sel_dividend == cache_dividend_q) &&
                     (sel_divisor == cache_divisor_q) && (sel_usigned == cache_usigned_q);
`else
  assign cache_hit = 1'b0;
`endif

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_found && req_valid[i] && (((int'(rr_ptr_q) + k) % NREQ) == i)) begin
          gnt_found = 1'b1;
          gnt_idx   = IDW'(i);
        end
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    sel_usigned  = 1'b0;
    sel_rem      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_dividend = req_dividend[i*parallelism +: parallelism];
        sel_divisor  = req_divisor[i*parallelism +: parallelism];
        sel_usigned  = req_usigned[i];
        sel_rem      = req_rem[i];
      end
    end
  end

  // Accept strobe is one-hot on the grant; held low during reset and outside IDLE.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && (state_q == S_IDLE) && gnt_found && (gnt_idx == IDW'(i));
    end
  end

  // Next-state and holding-register updates.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    op_dividend_d  = op_dividend_q;
    op_divisor_d   = op_divisor_q;
    op_usigned_d   = op_usigned_q;
    op_rem_d       = op_rem_q;
    rsp_id_d       = rsp_id_q;
    rsp_data_d     = rsp_data_q;
    rsp_divzero_d  = rsp_divzero_q;
    rsp_overflow_d = rsp_overflow_q;
`ifdef DIV_REUSE_EN
    cache_vld_d      = cache_vld_q;
    cache_dividend_d = cache_dividend_q;
    cache_divisor_d  = cache_divisor_q;
    cache_usigned_d  = cache_usigned_q;
    cache_quo_d      = cache_quo_q;
    cache_rem_d      = cache_rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          op_dividend_d  = sel_dividend;
          op_divisor_d   = sel_divisor;
          op_usigned_d   = sel_usigned;
          op_rem_d       = sel_rem;
          rsp_id_d       = gnt_idx;
          rr_ptr_d       = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
          rsp_divzero_d  = 1'b0;
          rsp_overflow_d = 1'b0;
          if (sel_divisor == '0) begin
            rsp_divzero_d = 1'b1;
            rsp_data_d    = sel_rem ? sel_dividend : '1;
            state_d       = S_RESP;
          end else if (!sel_usigned && (sel_dividend == MIN_NEG) && (sel_divisor == '1)) begin
            rsp_overflow_d = 1'b1;
            rsp_data_d     = sel_rem ? '0 : sel_dividend;
            state_d        = S_RESP;
          end else if (cache_hit) begin
`ifdef DIV_REUSE_EN
            rsp_data_d = sel_rem ? cache_rem_q : cache_quo_q;
`endif
            state_d    = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (div_res_ready) begin
          rsp_data_d = op_rem_q ? div_reminder : div_quotient;
          state_d    = S_RESP;
`ifdef DIV_REUSE_EN
          cache_vld_d      = 1'b1;
          cache_dividend_d = op_dividend_q;
          cache_divisor_d  = op_divisor_q;
          cache_usigned_d  = op_usigned_q;
          cache_quo_d      = div_quotient;
          cache_rem_d      = div_reminder;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and holding registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      op_dividend_q  <= '0;
      op_divisor_q   <= '0;
      op_usigned_q   <= 1'b0;
      op_rem_q       <= 1'b0;
      rsp_id_q       <= '0;
      rsp_data_q     <= '0;
      rsp_divzero_q  <= 1'b0;
      rsp_overflow_q <= 1'b0;
`ifdef DIV_REUSE_EN
      cache_vld_q      <= 1'b0;
      cache_dividend_q <= '0;
      cache_divisor_q  <= '0;
      cache_usigned_q  <= 1'b0;
      cache_quo_q      <= '0;
      cache_rem_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      op_dividend_q  <= op_dividend_d;
      op_divisor_q   <= op_divisor_d;
      op_usigned_q   <= op_usigned_d;
      op_rem_q       <= op_rem_d;
      rsp_id_q       <= rsp_id_d;
      rsp_data_q     <= rsp_data_d;
      rsp_divzero_q  <= rsp_divzero_d;
      rsp_overflow_q <= rsp_overflow_d;
`ifdef DIV_REUSE_EN
      cache_vld_q      <= cache_vld_d;
      cache_dividend_q <= cache_dividend_d;
      cache_divisor_q  <= cache_divisor_d;
      cache_usigned_q  <= cache_usigned_d;
      cache_quo_q      <= cache_quo_d;
      cache_rem_q      <= cache_rem_d;
`endif
    end
  end

  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_divzero  = rsp_divzero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign div_valid    = (state_q == S_ISSUE);
  assign div_usigned  = op_usigned_q;
  assign div_dividend = op_dividend_q;
  assign div_divisor  = op_divisor_q;

endmodule
